// File: rtl/lim_digit_chain.sv
//-----------------------------------------------------------------------------
// lim_digit_chain
//
// Stopwatch time base: a chain of DIGITS cascaded modulo counters. Digit k
// counts modulo its own limit (slice k of LIMITS, digit 0 in the LSB slice),
// and a carry ripples combinationally so every digit updates on one edge.
// Supports up/down counting, whole-chain wrap or saturate, synchronous
// clear, a lap-capture register and a one-cycle chain-wrap pulse.
//
// Parameters:
//   DIGITS  number of cascaded digits (1..8)
//   W       bits per digit
//   LIMITS  packed DIGITS*W moduli; a slice of 0 encodes a modulus of 2^W
//   WRAP    1 = chain wraps at terminal value, 0 = chain saturates (done)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   tick     in   single-cycle count strobe
//   en       in   count enable, qualifies tick
//   dir      in   0 = up, 1 = down, sampled with tick
//   clr      in   synchronous clear, wins over tick
//   lap      in   single-cycle capture strobe for lap_val
//   count    out  current digit values, digit k in slice k
//   lap_val  out  count value captured on the last lap strobe
//   co       out  one-cycle pulse after a chain wrap / saturation step
//   done     out  sticky saturation flag (WRAP=0 only)
//-----------------------------------------------------------------------------
`timescale 1ns / 1ps

module lim_digit_chain #(
  parameter int unsigned              DIGITS = 4,
  parameter int unsigned              W      = 4,
  parameter logic [DIGITS*W-1:0]      LIMITS = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter bit                       WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  lap,
  output logic [DIGITS*W-1:0]   count,
  output logic [DIGITS*W-1:0]   lap_val,
  output logic                  co,
  output logic                  done
);

  localparam int unsigned CW = DIGITS * W;

  // Highest legal value of digit k. Subtracting in W bits makes a slice of
  // 0 (modulus 2^W, not representable in W bits) map to all ones.
  function automatic logic [W-1:0] lim_top(input int k);
    logic [W-1:0] lim;
    lim = LIMITS[k*W +: W];
    return lim - W'(1);
  endfunction

  // Next value of one digit when it is allowed to move. The terminal test
  // is done first, so the value never leaves 0..top and never overflows W.
  function automatic logic [W-1:0] digit_next(input logic [W-1:0] d,
                                              input logic [W-1:0] top,
                                              input logic         down,
                                              input logic         term);
    if (term) begin
      return down ? top : '0;
    end
    return down ? (d - W'(1)) : (d + W'(1));
  endfunction

  logic [CW-1:0]     count_q,   count_d;
  logic [CW-1:0]     lap_val_q, lap_val_d;
  logic              co_q,      co_d;
  logic              done_q,    done_d;

  logic [DIGITS-1:0] term;
  logic              chain_term;
  logic              step;
  logic              carry;

  // Per-digit terminal flags for the current direction.
  always_comb begin
    term = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dir) begin
        term[k] = (count_q[k*W +: W] == '0);
      end else begin
        term[k] = (count_q[k*W +: W] == lim_top(k));
      end
    end
  end

  assign chain_term = &term;

  // A saturated chain (WRAP=0, done set) ignores ticks until cleared.
  assign step = tick & en & ~clr & ~(done_q & ~WRAP);

  always_comb begin
    count_d   = count_q;
    lap_val_d = lap_val_q;
    co_d      = 1'b0;
    done_d    = done_q;
    carry     = 1'b1;

    // Lap always sees the pre-update count, independent of en/done/clr.
    if (lap) begin
      lap_val_d = count_q;
    end

    if (clr) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (step) begin
      if (chain_term) begin
        co_d = 1'b1;
      end
      if (chain_term && !WRAP) begin
        // Saturate: hold count, latch done.
        done_d = 1'b1;
      end else begin
        // Digit k moves only when every lower digit is terminal.
        for (int k = 0; k < DIGITS; k++) begin
          if (carry) begin
            count_d[k*W +: W] = digit_next(count_q[k*W +: W], lim_top(k),
                                           dir, term[k]);
          end
          carry = carry & term[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      lap_val_q <= '0;
      co_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      lap_val_q <= lap_val_d;
      co_q      <= co_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_q;
  assign lap_val = lap_val_q;
  assign co      = co_q;
  assign done    = done_q;

endmodule
